// File: rtl/slurm16_dma_memcpy.sv
// slurm16_dma_memcpy: word-oriented DMA copy engine.
// Register-bus slave (SRC/DST/COUNT/CTRL-STATUS) and memory-arbiter master.
// Optional fill mode is compiled in when DMA_FILL_EN is defined.
module slurm16_dma_memcpy #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic [1:0]           reg_addr,
    input  logic [15:0]          reg_wr_data,
    input  logic                 reg_wr,
    output logic [15:0]          reg_rd_data,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wr_data,
    input  logic                 mem_gnt,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 irq
);

    typedef enum logic [1:0] {IDLE, RD, RD_DATA, WR} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
    logic                   done_q, done_d, aborted_q, aborted_d, fill_q, fill_d;
    logic                   req_q, req_d, wr_q, wr_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;

    logic ctrl_wr, start, abort, clear, fill_req, busy;

    assign ctrl_wr = reg_wr && (reg_addr == 2'd3);
    assign start   = ctrl_wr && reg_wr_data[0];
    assign abort   = ctrl_wr && reg_wr_data[1];
    assign clear   = ctrl_wr && reg_wr_data[2];
    assign busy    = (state_q != IDLE);

`ifdef DMA_FILL_EN
    assign fill_req = reg_wr_data[3];
`else
    assign fill_req = 1'b0;
`endif

    assign mem_req     = req_q;
    assign mem_wr      = wr_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign irq         = done_q;

    // Register read mux: live counters plus status bits
    always_comb begin
        reg_rd_data = '0;
        case (reg_addr)
            2'd0:    reg_rd_data = 16'(src_q);
            2'd1:    reg_rd_data = 16'(dst_q);
            2'd2:    reg_rd_data = 16'(cnt_q);
            default: reg_rd_data = {12'h000, fill_q, aborted_q, done_q, busy};
        endcase
    end

    // Next-state, register updates and registered memory-port outputs
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        fill_d    = fill_q;

        // Clear is applied first so a completion in the same cycle overrides it
        if (clear) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    fill_d    = fill_req;
                    if (cnt_q == '0) done_d = 1'b1;
                    else             state_d = fill_req ? WR : RD;
                end else if (reg_wr) begin
                    case (reg_addr)
                        2'd0:    src_d = ADDR_BITS'(reg_wr_data);
                        2'd1:    dst_d = ADDR_BITS'(reg_wr_data);
                        2'd2:    cnt_d = ADDR_BITS'(reg_wr_data);
                        default: ;
                    endcase
                end
            end
            RD:      if (mem_gnt) state_d = RD_DATA;
            RD_DATA: state_d = WR;
            WR: begin
                if (mem_gnt) begin
                    src_d = fill_q ? src_q : src_q + 1'b1;
                    dst_d = dst_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_BITS'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = fill_q ? WR : RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort keeps any counter progress from a write granted this cycle
        if (busy && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
        end

        req_d   = (state_d == RD) || (state_d == WR);
        wr_d    = (state_d == WR);
        addr_d  = addr_q;
        if (state_d == RD)      addr_d = src_d;
        else if (state_d == WR) addr_d = dst_d;
        wdata_d = wdata_q;
        if (state_q == RD_DATA)              wdata_d = mem_rd_data;
        else if (state_d == WR && fill_d)    wdata_d = DATA_BITS'(src_d);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            fill_q    <= 1'b0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            fill_q    <= fill_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule
